// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU request-side controller: opcodes,
// rounding modes, flag bit positions and controller state encodings.
package fpu_pkg;

  localparam logic [6:0] FADD_S   = 7'b0000000;
  localparam logic [6:0] FADD_D   = 7'b0000001;
  localparam logic [6:0] FSUB_S   = 7'b0000100;
  localparam logic [6:0] FSUB_D   = 7'b0000101;
  localparam logic [6:0] FCMP_S   = 7'b1010000;
  localparam logic [6:0] FCMP_D   = 7'b1010001;
  localparam logic [6:0] FCVT_D_S = 7'b0100001;
  localparam logic [6:0] FCVT_W_S = 7'b1100000;
  localparam logic [6:0] FCVT_D_W = 7'b1101001;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;
  localparam logic [2:0] RM_DYN = 3'b111;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  // state | meaning
  // IDLE  | waiting for a request, req_ready high
  // EXEC  | operands held on fpu_*, latency counter running
  // RESP  | response held until the consumer accepts it
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Compare ops return a single bit instead of the FPU result word.
  function automatic logic is_cmp(input logic [6:0] func7);
    return (func7 == FCMP_S) || (func7 == FCMP_D);
  endfunction

  // Encodings 101, 110 and 111 are reserved once dynamic mode is resolved.
  function automatic logic rm_legal(input logic [2:0] rm);
    return rm <= RM_RMM;
  endfunction

endpackage

// File: rtl/fpu_issue_ctrl.sv
// FPU issue controller: accepts one op at a time, resolves the dynamic
// rounding mode, drives registered FPU inputs, waits a fixed latency and
// returns the captured result plus status flags. Keeps sticky fflags.
module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int unsigned LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [6:0]  req_func7,
  input  logic [2:0]  req_func3,
  input  logic [2:0]  req_rm,
  input  logic        req_cvt_wu,
  input  logic [63:0] req_a,
  input  logic [63:0] req_b,
  input  logic [2:0]  csr_frm,
  input  logic        clear_flags,
  output logic [6:0]  fpu_func7,
  output logic [2:0]  fpu_func3,
  output logic [2:0]  fpu_rm,
  output logic        fpu_cvt_wu,
  output logic [63:0] fpu_a,
  output logic [63:0] fpu_b,
  input  logic [63:0] fpu_result,
  input  logic        fpu_nv,
  input  logic        fpu_dz,
  input  logic        fpu_of,
  input  logic        fpu_uf,
  input  logic        fpu_nx,
  input  logic        fpu_cmp,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_data,
  output logic [4:0]  rsp_flags,
  output logic        rsp_illegal,
  output logic [4:0]  fflags
);

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [2:0]  rm_eff;
  logic        accept;
  logic        accept_ok;
  logic        capture;
  logic [4:0]  cap_flags;
  logic [63:0] cap_data;

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign rm_eff    = (req_rm == RM_DYN) ? csr_frm : req_rm;
  assign accept    = req_ready && req_valid;
  assign accept_ok = accept && rm_legal(rm_eff);
  assign capture   = (state == S_EXEC) && (cnt == 4'd0);
  assign cap_flags = {fpu_nv, fpu_dz, fpu_of, fpu_uf, fpu_nx};
  assign cap_data  = is_cmp(fpu_func7) ? {63'b0, fpu_cmp} : fpu_result;

  // State machine and latency down-counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept_ok) begin
            state <= S_EXEC;
            cnt   <= CNT_LOAD;
          end else if (accept) begin
            state <= S_RESP;
          end
        end
        S_EXEC: begin
          if (capture) state <= S_RESP;
          else         cnt   <= cnt - 4'd1;
        end
        S_RESP: begin
          if (rsp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // FPU input registers, loaded only by a legal accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpu_func7  <= '0;
      fpu_func3  <= '0;
      fpu_rm     <= '0;
      fpu_cvt_wu <= 1'b0;
      fpu_a      <= '0;
      fpu_b      <= '0;
    end else if (accept_ok) begin
      fpu_func7  <= req_func7;
      fpu_func3  <= req_func3;
      fpu_rm     <= rm_eff;
      fpu_cvt_wu <= req_cvt_wu;
      fpu_a      <= req_a;
      fpu_b      <= req_b;
    end
  end

  // Response registers: captured result, or a zeroed illegal-rm response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data    <= '0;
      rsp_flags   <= '0;
      rsp_illegal <= 1'b0;
    end else if (accept && !accept_ok) begin
      rsp_data    <= '0;
      rsp_flags   <= '0;
      rsp_illegal <= 1'b1;
    end else if (capture) begin
      rsp_data  <= cap_data;
      rsp_flags <= cap_flags;
    end else if (rsp_valid && rsp_ready) begin
      rsp_illegal <= 1'b0;
    end
  end

  // Sticky accrued flags; a same-cycle capture survives a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fflags <= '0;
    end else if (clear_flags) begin
      fflags <= capture ? cap_flags : 5'b0;
    end else if (capture) begin
      fflags <= fflags | cap_flags;
    end
  end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl: one instance at LATENCY=1, one at
// LATENCY=3. The bench plays the FPU by driving fpu_result/flags directly.
module tb_fpu_issue_ctrl;
  import fpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid_1, req_valid_3;
  logic [6:0]  req_func7;
  logic [2:0]  req_func3, req_rm, csr_frm;
  logic        req_cvt_wu, clear_flags;
  logic [63:0] req_a, req_b, fpu_result;
  logic        fpu_nv, fpu_dz, fpu_of, fpu_uf, fpu_nx, fpu_cmp;
  logic        rsp_ready_1, rsp_ready_3;

  logic        req_ready_1, rsp_valid_1, rsp_illegal_1, fpu_cvt_wu_1;
  logic [6:0]  fpu_func7_1;
  logic [2:0]  fpu_func3_1, fpu_rm_1;
  logic [63:0] fpu_a_1, fpu_b_1, rsp_data_1;
  logic [4:0]  rsp_flags_1, fflags_1;

  logic        req_ready_3, rsp_valid_3, rsp_illegal_3, fpu_cvt_wu_3;
  logic [6:0]  fpu_func7_3;
  logic [2:0]  fpu_func3_3, fpu_rm_3;
  logic [63:0] fpu_a_3, fpu_b_3, rsp_data_3;
  logic [4:0]  rsp_flags_3, fflags_3;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fpu_issue_ctrl #(.LATENCY(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid_1), .req_ready(req_ready_1),
    .req_func7(req_func7), .req_func3(req_func3), .req_rm(req_rm),
    .req_cvt_wu(req_cvt_wu), .req_a(req_a), .req_b(req_b),
    .csr_frm(csr_frm), .clear_flags(clear_flags),
    .fpu_func7(fpu_func7_1), .fpu_func3(fpu_func3_1), .fpu_rm(fpu_rm_1),
    .fpu_cvt_wu(fpu_cvt_wu_1), .fpu_a(fpu_a_1), .fpu_b(fpu_b_1),
    .fpu_result(fpu_result), .fpu_nv(fpu_nv), .fpu_dz(fpu_dz),
    .fpu_of(fpu_of), .fpu_uf(fpu_uf), .fpu_nx(fpu_nx), .fpu_cmp(fpu_cmp),
    .rsp_valid(rsp_valid_1), .rsp_ready(rsp_ready_1),
    .rsp_data(rsp_data_1), .rsp_flags(rsp_flags_1),
    .rsp_illegal(rsp_illegal_1), .fflags(fflags_1)
  );

  fpu_issue_ctrl #(.LATENCY(3)) u_lat3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid_3), .req_ready(req_ready_3),
    .req_func7(req_func7), .req_func3(req_func3), .req_rm(req_rm),
    .req_cvt_wu(req_cvt_wu), .req_a(req_a), .req_b(req_b),
    .csr_frm(csr_frm), .clear_flags(clear_flags),
    .fpu_func7(fpu_func7_3), .fpu_func3(fpu_func3_3), .fpu_rm(fpu_rm_3),
    .fpu_cvt_wu(fpu_cvt_wu_3), .fpu_a(fpu_a_3), .fpu_b(fpu_b_3),
    .fpu_result(fpu_result), .fpu_nv(fpu_nv), .fpu_dz(fpu_dz),
    .fpu_of(fpu_of), .fpu_uf(fpu_uf), .fpu_nx(fpu_nx), .fpu_cmp(fpu_cmp),
    .rsp_valid(rsp_valid_3), .rsp_ready(rsp_ready_3),
    .rsp_data(rsp_data_3), .rsp_flags(rsp_flags_3),
    .rsp_illegal(rsp_illegal_3), .fflags(fflags_3)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the target idle; returns at the negedge after accept.
  task automatic issue(input bit sel, input logic [6:0] f7, input logic [2:0] f3,
                       input logic [2:0] rm, input logic cvt,
                       input logic [63:0] a, input logic [63:0] b);
    req_func7  = f7;
    req_func3  = f3;
    req_rm     = rm;
    req_cvt_wu = cvt;
    req_a      = a;
    req_b      = b;
    if (sel) req_valid_3 = 1'b1;
    else     req_valid_1 = 1'b1;
    @(negedge clk);
    req_valid_1 = 1'b0;
    req_valid_3 = 1'b0;
  endtask

  // Counts cycles after accept until rsp_valid; bounded.
  task automatic wait_rsp(input bit sel, output int cyc);
    cyc = 0;
    while (!(sel ? rsp_valid_3 : rsp_valid_1) && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic handshake(input bit sel);
    if (sel) rsp_ready_3 = 1'b1;
    else     rsp_ready_1 = 1'b1;
    @(negedge clk);
    rsp_ready_1 = 1'b0;
    rsp_ready_3 = 1'b0;
    check("hs_rsp_valid_low", sel ? rsp_valid_3 : rsp_valid_1, 0);
    check("hs_req_ready_high", sel ? req_ready_3 : req_ready_1, 1);
  endtask

  initial begin
    int cyc;
    bit seen;
    rst_n = 1'b0;
    req_valid_1 = 0; req_valid_3 = 0; rsp_ready_1 = 0; rsp_ready_3 = 0;
    req_func7 = '0; req_func3 = '0; req_rm = '0; req_cvt_wu = 0;
    req_a = '0; req_b = '0; csr_frm = '0; clear_flags = 0;
    fpu_result = '0; fpu_cmp = 0;
    {fpu_nv, fpu_dz, fpu_of, fpu_uf, fpu_nx} = 5'b0;
    repeat (2) @(negedge clk);

    check("rst_req_ready", req_ready_1, 1);
    check("rst_rsp_valid", rsp_valid_1, 0);
    check("rst_rsp_illegal", rsp_illegal_1, 0);
    check("rst_rsp_data", rsp_data_1, 0);
    check("rst_fflags", fflags_1, 0);
    check("rst_fpu_a", fpu_a_3, 0);
    check("rst_fpu_func7", fpu_func7_3, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // add, LATENCY=1
    fpu_result = 64'h0000_0000_4040_0000;
    issue(0, FADD_S, 3'b000, RM_RNE, 0, 64'h3F80_0000, 64'h4000_0000);
    check("add_fpu_a", fpu_a_1, 64'h3F80_0000);
    check("add_fpu_b", fpu_b_1, 64'h4000_0000);
    check("add_fpu_func7", fpu_func7_1, FADD_S);
    check("add_req_ready_busy", req_ready_1, 0);
    wait_rsp(0, cyc);
    check("add_latency", cyc, 1);
    check("add_rsp_data", rsp_data_1, 64'h0000_0000_4040_0000);
    check("add_rsp_flags", rsp_flags_1, 0);
    check("add_fflags", fflags_1, 0);
    check("add_rsp_illegal", rsp_illegal_1, 0);
    handshake(0);

    // inf - inf -> invalid, QNaN passes through
    fpu_result = 64'h0000_0000_7FC0_0000;
    fpu_nv = 1;
    issue(0, FADD_S, 3'b000, RM_RNE, 0, 64'h7F80_0000, 64'hFF80_0000);
    wait_rsp(0, cyc);
    check("inv_rsp_flags", rsp_flags_1, 5'b10000);
    check("inv_rsp_data", rsp_data_1, 64'h7FC0_0000);
    check("inv_fflags", fflags_1, 5'b10000);
    handshake(0);

    // NX op with clear_flags on the capture edge: new bits survive, old NV cleared
    fpu_nv = 0; fpu_nx = 1;
    issue(0, FSUB_S, 3'b000, RM_RNE, 0, 64'h1, 64'h2);
    clear_flags = 1;
    @(negedge clk);
    clear_flags = 0;
    check("clr_cap_rsp_valid", rsp_valid_1, 1);
    check("clr_cap_fflags", fflags_1, 5'b00001);
    handshake(0);

    // sticky accumulate, then clear with no op
    fpu_nx = 0; fpu_of = 1;
    issue(0, FADD_D, 3'b000, RM_RNE, 0, 64'h3, 64'h4);
    wait_rsp(0, cyc);
    check("sticky_fflags", fflags_1, 5'b00101);
    handshake(0);
    fpu_of = 0;
    clear_flags = 1;
    @(negedge clk);
    clear_flags = 0;
    check("clear_fflags", fflags_1, 0);

    // dynamic rm resolves to csr_frm
    csr_frm = RM_RTZ;
    fpu_result = 64'h5;
    issue(0, FCVT_W_S, 3'b000, RM_DYN, 1, 64'h40A0_0000, 64'h0);
    check("dyn_fpu_rm", fpu_rm_1, RM_RTZ);
    check("dyn_fpu_cvt_wu", fpu_cvt_wu_1, 1);
    wait_rsp(0, cyc);
    check("dyn_rsp_data", rsp_data_1, 64'h5);
    handshake(0);

    // dynamic rm with reserved csr_frm: rejected, FPU side and fflags untouched
    csr_frm = 3'b101;
    fpu_nx = 1;
    issue(0, FADD_S, 3'b000, RM_DYN, 0, 64'hAAAA, 64'hBBBB);
    check("ill_rsp_valid", rsp_valid_1, 1);
    check("ill_rsp_illegal", rsp_illegal_1, 1);
    check("ill_rsp_data", rsp_data_1, 0);
    check("ill_rsp_flags", rsp_flags_1, 0);
    check("ill_fpu_rm", fpu_rm_1, RM_RTZ);
    check("ill_fpu_a", fpu_a_1, 64'h40A0_0000);
    check("ill_fpu_func7", fpu_func7_1, FCVT_W_S);
    @(negedge clk);
    check("ill_fflags", fflags_1, 0);
    check("ill_held", rsp_illegal_1, 1);
    handshake(0);
    check("ill_cleared", rsp_illegal_1, 0);
    fpu_nx = 0;

    // compare returns the cmp bit only
    fpu_result = 64'hDEAD_BEEF_0000_0000;
    fpu_cmp = 1;
    issue(0, FCMP_S, 3'b010, RM_RNE, 0, 64'h3F80_0000, 64'h3F80_0000);
    check("cmp_fpu_func3", fpu_func3_1, 3'b010);
    wait_rsp(0, cyc);
    check("cmp_rsp_data", rsp_data_1, 64'h1);
    check("cmp_rsp_flags", rsp_flags_1, 0);
    handshake(0);
    fpu_cmp = 0;

    // LATENCY=3 with 4 cycles of backpressure
    fpu_result = 64'h1234_5678_9ABC_DEF0;
    issue(1, FADD_D, 3'b000, RM_RUP, 0, 64'h11, 64'h22);
    wait_rsp(1, cyc);
    check("bp_latency", cyc, 3);
    fpu_result = 64'h0;
    for (int i = 0; i < 4; i++) begin
      check("bp_rsp_valid", rsp_valid_3, 1);
      check("bp_rsp_data", rsp_data_3, 64'h1234_5678_9ABC_DEF0);
      check("bp_req_ready", req_ready_3, 0);
      @(negedge clk);
    end
    handshake(1);

    // reset in the second EXEC cycle abandons the op
    fpu_nv = 1;
    issue(1, FSUB_D, 3'b000, RM_RNE, 0, 64'h55, 64'h66);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rstx_rsp_valid", rsp_valid_3, 0);
    check("rstx_fpu_a", fpu_a_3, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid_3) seen = 1;
    end
    check("rstx_no_rsp", seen, 0);
    check("rstx_fflags", fflags_3, 0);
    check("rstx_req_ready", req_ready_3, 1);
    fpu_nv = 0;
    fpu_result = 64'h77;
    issue(1, FADD_D, 3'b000, RM_RDN, 0, 64'h1, 64'h2);
    check("post_rst_fpu_rm", fpu_rm_3, RM_RDN);
    wait_rsp(1, cyc);
    check("post_rst_latency", cyc, 3);
    check("post_rst_rsp_data", rsp_data_3, 64'h77);
    handshake(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
